data_sram_resp: RTL and testbench



---
 rtl/data_sram_resp_pkg.sv | 31 +++
 rtl/data_sram_resp_ram_bank.sv | 31 +++
 rtl/data_sram_resp.sv | 102 ++++++++++
 tb/tb_data_sram_resp.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/data_sram_resp_pkg.sv
// Shared definitions for the CPU data-SRAM responder: window defaults,
// register offsets, read-mux selects and the byte-lane merge helper.
package data_sram_resp_pkg;

  localparam logic [31:0] CONF_BASE_DEFAULT = 32'hBFAF_0000;
  localparam logic [31:0] CONF_MASK_DEFAULT = 32'hFFFF_0000;

  localparam logic [15:0] OFF_LED     = 16'h0000;
  localparam logic [15:0] OFF_SWITCH  = 16'h0004;
  localparam logic [15:0] OFF_NUM     = 16'h0008;
  localparam logic [15:0] OFF_TIMER   = 16'h000C;
  localparam logic [15:0] OFF_SCRATCH = 16'h0010;

  typedef enum logic [1:0] {
    SEL_ZERO = 2'd0,
    SEL_RAM  = 2'd1,
    SEL_REG  = 2'd2
  } rd_sel_e;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  wen);
    logic [31:0] merged;
    merged = old_word;
    for (int i = 0; i < 4; i++) begin
      if (wen[i]) merged[8*i +: 8] = wdata[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/data_sram_resp_ram_bank.sv
// Single-port word RAM with per-byte write enables and a registered,
// write-first read port; the read register only moves on an enabled access.
module data_ram_bank
  import data_sram_resp_pkg::*;
#(
  parameter int AW = 14
) (
  input  logic          clk,
  input  logic          en,
  input  logic [3:0]    wen,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [2**AW];
  logic [31:0] merged_p0;

  assign merged_p0 = byte_merge(mem[addr], wdata, wen);

  // p0 -> p1: lane writes and write-first read capture
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 4; i++) begin
        if (wen[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
      rdata <= merged_p0;
    end
  end

endmodule

// File: rtl/data_sram_resp.sv
// Data-SRAM responder: decodes each request to the data RAM or the
// LED/switch/number/timer/scratch register window, returning data one cycle later.
module data_sram_resp
  import data_sram_resp_pkg::*;
#(
  parameter int          RAM_AW    = 14,
  parameter logic [31:0] CONF_BASE = CONF_BASE_DEFAULT,
  parameter logic [31:0] CONF_MASK = CONF_MASK_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  input  logic [7:0]  switch,
  output logic [15:0] led,
  output logic [31:0] num_data
);

  logic        vld_p0, hit_p0, wr_p0, ram_en_p0;
  logic [15:0] off_p0;
  logic [31:0] led_mrg, num_mrg, scratch_mrg, timer_mrg, timer_inc;
  logic [31:0] timer_q, scratch_q;
  logic [31:0] reg_rd_p0, reg_rd_p1, ram_rd_p1;
  logic [7:0]  sw_s1, sw_s2;
  rd_sel_e     sel_p1;
  logic        unused_ok;

  assign hit_p0    = (data_sram_addr & CONF_MASK) == CONF_BASE;
  assign off_p0    = data_sram_addr[15:0];
  assign vld_p0    = data_sram_en && !rst;
  assign wr_p0     = vld_p0 && hit_p0 && (data_sram_wen != 4'b0000);
  assign ram_en_p0 = vld_p0 && !hit_p0;

  assign timer_inc   = timer_q + 32'd1;
  assign led_mrg     = byte_merge({16'h0000, led}, data_sram_wdata, data_sram_wen);
  assign num_mrg     = byte_merge(num_data, data_sram_wdata, data_sram_wen);
  assign scratch_mrg = byte_merge(scratch_q, data_sram_wdata, data_sram_wen);
  assign timer_mrg   = byte_merge(timer_inc, data_sram_wdata, data_sram_wen);

  assign unused_ok = ^{data_sram_addr[1:0], led_mrg[31:16]};

  data_ram_bank #(.AW(RAM_AW)) u_ram (
    .clk   (clk),
    .en    (ram_en_p0),
    .wen   (data_sram_wen),
    .addr  (data_sram_addr[RAM_AW+1:2]),
    .wdata (data_sram_wdata),
    .rdata (ram_rd_p1)
  );

  // Merged values equal the old contents when wen is 0, so reads are write-first for free;
  // the timer is the exception because its merge base is the incremented value.
  always_comb begin
    reg_rd_p0 = 32'h0000_0000;
    case (off_p0)
      OFF_LED:     reg_rd_p0 = {16'h0000, led_mrg[15:0]};
      OFF_SWITCH:  reg_rd_p0 = {24'h00_0000, sw_s2};
      OFF_NUM:     reg_rd_p0 = num_mrg;
      OFF_TIMER:   reg_rd_p0 = (data_sram_wen != 4'b0000) ? timer_mrg : timer_q;
      OFF_SCRATCH: reg_rd_p0 = scratch_mrg;
      default:     reg_rd_p0 = 32'h0000_0000;
    endcase
  end

  // p0 -> p1: register file, timer, synchronizer and registered read select
  always_ff @(posedge clk) begin
    if (rst) begin
      led       <= 16'h0000;
      num_data  <= 32'h0000_0000;
      timer_q   <= 32'h0000_0000;
      scratch_q <= 32'h0000_0000;
      sw_s1     <= 8'h00;
      sw_s2     <= 8'h00;
      sel_p1    <= SEL_ZERO;
    end else begin
      sw_s1   <= switch;
      sw_s2   <= sw_s1;
      timer_q <= (wr_p0 && off_p0 == OFF_TIMER) ? timer_mrg : timer_inc;
      if (wr_p0 && off_p0 == OFF_LED)     led       <= led_mrg[15:0];
      if (wr_p0 && off_p0 == OFF_NUM)     num_data  <= num_mrg;
      if (wr_p0 && off_p0 == OFF_SCRATCH) scratch_q <= scratch_mrg;
      if (vld_p0) sel_p1 <= hit_p0 ? SEL_REG : SEL_RAM;
    end
  end

  always_ff @(posedge clk) begin
    if (vld_p0 && hit_p0) reg_rd_p1 <= reg_rd_p0;
  end

  always_comb begin
    data_sram_rdata = 32'h0000_0000;
    case (sel_p1)
      SEL_RAM: data_sram_rdata = ram_rd_p1;
      SEL_REG: data_sram_rdata = reg_rd_p1;
      default: data_sram_rdata = 32'h0000_0000;
    endcase
  end

endmodule

// File: tb/tb_data_sram_resp.sv
// Self-checking bench for data_sram_resp: directed scenarios plus randomized
// traffic compared against a cycle-level behavioural model.
module tb_data_sram_resp;

  localparam logic [31:0] BASE = 32'hBFAF_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [3:0]  wen;
  logic [31:0] addr, wdata, rdata;
  logic [7:0]  sw;
  logic [15:0] led;
  logic [31:0] num;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  logic [31:0] m_mem [int];
  logic [15:0] m_led;
  logic [31:0] m_num, m_scratch;
  logic [31:0] m_tbase, m_tload, m_cyc;
  logic [7:0]  m_sw1, m_sw2;
  logic [31:0] exp_rd;
  bit          exp_ok;

  data_sram_resp dut (
    .clk             (clk),
    .rst             (rst),
    .data_sram_en    (en),
    .data_sram_wen   (wen),
    .data_sram_addr  (addr),
    .data_sram_wdata (wdata),
    .data_sram_rdata (rdata),
    .switch          (sw),
    .led             (led),
    .num_data        (num)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] d,
                                        input logic [3:0] w);
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++) if (w[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  // Presents one request for one cycle and advances the model by that cycle.
  task automatic do_req(input logic e, input logic [3:0] w, input logic [31:0] a,
                        input logic [31:0] d);
    logic [31:0] tnow, nv;
    int idx;
    en = e; wen = w; addr = a; wdata = d;
    tnow = m_tbase + (m_cyc - m_tload);
    if (rst) begin
      exp_rd = 32'h0; exp_ok = 1'b1;
      m_led = 16'h0; m_num = 32'h0; m_scratch = 32'h0;
      m_tbase = 32'h0; m_tload = m_cyc + 32'd1;
      m_sw1 = 8'h0; m_sw2 = 8'h0;
    end else begin
      if (e) begin
        if ((a & 32'hFFFF_0000) == BASE) begin
          exp_ok = 1'b1;
          case (a[15:0])
            16'h0000: begin nv = merge({16'h0, m_led}, d, w); m_led = nv[15:0]; exp_rd = {16'h0, nv[15:0]}; end
            16'h0004: exp_rd = {24'h0, m_sw2};
            16'h0008: begin m_num = merge(m_num, d, w); exp_rd = m_num; end
            16'h000C: begin
              if (w != 4'h0) begin
                nv = merge(tnow + 32'd1, d, w);
                m_tbase = nv; m_tload = m_cyc + 32'd1; exp_rd = nv;
              end else exp_rd = tnow;
            end
            16'h0010: begin m_scratch = merge(m_scratch, d, w); exp_rd = m_scratch; end
            default:  exp_rd = 32'h0;
          endcase
        end else begin
          idx = int'(a[15:2]);
          if (m_mem.exists(idx)) begin nv = merge(m_mem[idx], d, w); exp_ok = 1'b1; end
          else if (w == 4'hF) begin nv = d; exp_ok = 1'b1; end
          else begin nv = 32'hx; exp_ok = 1'b0; end
          if (w != 4'h0 && exp_ok) m_mem[idx] = nv;
          exp_rd = nv;
        end
      end
      m_sw2 = m_sw1; m_sw1 = sw;
    end
    @(posedge clk); #1;
    m_cyc = m_cyc + 32'd1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    do_req(1'b0, 4'h0, 32'h0, 32'h0);
    do_req(1'b1, 4'hF, BASE, 32'hFFFF_FFFF);
    rst = 1'b0;
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected %h", rdata, 32'h0); end
    checks++; if (led !== 16'h0) begin errors++; $display("FAIL reset_led: got %h expected %h", led, 16'h0); end
    checks++; if (num !== 32'h0) begin errors++; $display("FAIL reset_num: got %h expected %h", num, 32'h0); end
    do_req(1'b1, 4'h0, BASE + 32'hC, 32'h0);
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_timer: got %h expected %h", rdata, 32'h0); end
  endtask

  task automatic test_ram_basic();
    do_req(1'b1, 4'hF, 32'h0000_0100, 32'h1122_3344);
    checks++; if (rdata !== 32'h1122_3344) begin errors++; $display("FAIL ram_write_first: got %h expected %h", rdata, 32'h1122_3344); end
    do_req(1'b1, 4'h0, 32'h0000_0100, 32'h0);
    checks++; if (rdata !== 32'h1122_3344) begin errors++; $display("FAIL ram_read: got %h expected %h", rdata, 32'h1122_3344); end
    do_req(1'b1, 4'b0100, 32'h0000_0100, 32'hAAAA_AAAA);
    do_req(1'b1, 4'h0, 32'h0000_0100, 32'h0);
    checks++; if (rdata !== 32'h11AA_3344) begin errors++; $display("FAIL ram_lane: got %h expected %h", rdata, 32'h11AA_3344); end
    do_req(1'b0, 4'hF, 32'h0000_0100, 32'hFFFF_FFFF);
    checks++; if (rdata !== 32'h11AA_3344) begin errors++; $display("FAIL ram_hold: got %h expected %h", rdata, 32'h11AA_3344); end
    do_req(1'b1, 4'h0, 32'h0000_0100, 32'h0);
    checks++; if (rdata !== 32'h11AA_3344) begin errors++; $display("FAIL ram_en0_nowrite: got %h expected %h", rdata, 32'h11AA_3344); end
  endtask

  task automatic test_regs();
    do_req(1'b1, 4'hF, BASE, 32'h0000_BEEF);
    checks++; if (led !== 16'hBEEF) begin errors++; $display("FAIL led_write: got %h expected %h", led, 16'hBEEF); end
    do_req(1'b1, 4'h0, BASE, 32'h0);
    checks++; if (rdata !== 32'h0000_BEEF) begin errors++; $display("FAIL led_read: got %h expected %h", rdata, 32'h0000_BEEF); end
    do_req(1'b1, 4'hF, BASE + 32'h8, 32'h1234_5678);
    do_req(1'b1, 4'b1000, BASE + 32'h8, 32'hABAB_ABAB);
    checks++; if (num !== 32'hAB34_5678) begin errors++; $display("FAIL num_lane: got %h expected %h", num, 32'hAB34_5678); end
    do_req(1'b1, 4'b0011, BASE + 32'h10, 32'h0000_C0DE);
    do_req(1'b1, 4'h0, BASE + 32'h10, 32'h0);
    checks++; if (rdata !== 32'h0000_C0DE) begin errors++; $display("FAIL scratch_read: got %h expected %h", rdata, 32'h0000_C0DE); end
  endtask

  task automatic test_timer();
    do_req(1'b1, 4'hF, BASE + 32'hC, 32'hFFFF_FFFE);
    do_req(1'b0, 4'h0, 32'h0, 32'h0);
    do_req(1'b1, 4'h0, BASE + 32'hC, 32'h0);
    checks++; if (rdata !== 32'hFFFF_FFFF) begin errors++; $display("FAIL timer_max: got %h expected %h", rdata, 32'hFFFF_FFFF); end
    do_req(1'b1, 4'h0, BASE + 32'hC, 32'h0);
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL timer_wrap: got %h expected %h", rdata, 32'h0); end
  endtask

  task automatic test_switch();
    sw = 8'hA5;
    do_req(1'b0, 4'h0, 32'h0, 32'h0);
    do_req(1'b0, 4'h0, 32'h0, 32'h0);
    do_req(1'b1, 4'h0, BASE + 32'h4, 32'h0);
    checks++; if (rdata !== 32'h0000_00A5) begin errors++; $display("FAIL switch_read: got %h expected %h", rdata, 32'h0000_00A5); end
    do_req(1'b1, 4'hF, BASE + 32'h4, 32'hFFFF_FFFF);
    do_req(1'b1, 4'h0, BASE + 32'h4, 32'h0);
    checks++; if (rdata !== 32'h0000_00A5) begin errors++; $display("FAIL switch_ro: got %h expected %h", rdata, 32'h0000_00A5); end
    do_req(1'b1, 4'hF, BASE + 32'h20, 32'h5555_5555);
    do_req(1'b1, 4'h0, BASE + 32'h20, 32'h0);
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL unmapped_read: got %h expected %h", rdata, 32'h0); end
  endtask

  task automatic test_back_to_back();
    do_req(1'b1, 4'hF, 32'h0000_0180, 32'hCAFE_F00D);
    do_req(1'b1, 4'h0, 32'h0000_0180, 32'h0);
    checks++; if (rdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL b2b_wr_rd: got %h expected %h", rdata, 32'hCAFE_F00D); end
    do_req(1'b1, 4'hF, 32'h0000_0184, 32'h0BAD_BEEF);
    do_req(1'b1, 4'h0, 32'h0000_0180, 32'h0);
    checks++; if (rdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL b2b_other: got %h expected %h", rdata, 32'hCAFE_F00D); end
    do_req(1'b1, 4'h0, 32'h0000_0184, 32'h0);
    checks++; if (rdata !== 32'h0BAD_BEEF) begin errors++; $display("FAIL b2b_second: got %h expected %h", rdata, 32'h0BAD_BEEF); end
  endtask

  task automatic test_random();
    logic [15:0] offs [6];
    logic [31:0] a;
    offs[0] = 16'h0000; offs[1] = 16'h0004; offs[2] = 16'h0008;
    offs[3] = 16'h000C; offs[4] = 16'h0010; offs[5] = 16'h0020;
    for (int i = 0; i < 8; i++) do_req(1'b1, 4'hF, 32'h0000_0400 + 32'(4 * i), $urandom);
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 15) == 0) sw = 8'($urandom);
      if ($urandom_range(0, 1) == 0) a = 32'h0000_0400 + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
      else a = BASE + {16'h0, offs[$urandom_range(0, 5)]};
      do_req($urandom_range(0, 3) != 0, 4'($urandom), a, $urandom);
      if (exp_ok) begin
        checks++; if (rdata !== exp_rd) begin errors++; $display("FAIL rand_rdata[%0d]: got %h expected %h", n, rdata, exp_rd); end
      end
      checks++; if (led !== m_led) begin errors++; $display("FAIL rand_led[%0d]: got %h expected %h", n, led, m_led); end
      checks++; if (num !== m_num) begin errors++; $display("FAIL rand_num[%0d]: got %h expected %h", n, num, m_num); end
    end
  endtask

  task automatic test_reset_write();
    do_req(1'b1, 4'hF, 32'h0000_0200, 32'h5A5A_5A5A);
    do_req(1'b1, 4'hF, BASE, 32'h0000_1234);
    rst = 1'b1;
    do_req(1'b1, 4'hF, 32'h0000_0200, 32'hDEAD_BEEF);
    rst = 1'b0;
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL rst_wr_rdata: got %h expected %h", rdata, 32'h0); end
    checks++; if (led !== 16'h0) begin errors++; $display("FAIL rst_wr_led: got %h expected %h", led, 16'h0); end
    checks++; if (num !== 32'h0) begin errors++; $display("FAIL rst_wr_num: got %h expected %h", num, 32'h0); end
    do_req(1'b1, 4'h0, 32'h0000_0200, 32'h0);
    checks++; if (rdata !== 32'h5A5A_5A5A) begin errors++; $display("FAIL rst_wr_ram: got %h expected %h", rdata, 32'h5A5A_5A5A); end
    do_req(1'b1, 4'h0, BASE + 32'hC, 32'h0);
    checks++; if (rdata !== 32'h1) begin errors++; $display("FAIL rst_wr_timer: got %h expected %h", rdata, 32'h1); end
    checks++; if (rdata !== exp_rd) begin errors++; $display("FAIL rst_wr_timer_model: got %h expected %h", rdata, exp_rd); end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; wen = 4'h0; addr = 32'h0; wdata = 32'h0; sw = 8'h00;
    m_cyc = 32'h0; m_tbase = 32'h0; m_tload = 32'h0;
    m_led = 16'h0; m_num = 32'h0; m_scratch = 32'h0; m_sw1 = 8'h0; m_sw2 = 8'h0;
    exp_rd = 32'h0; exp_ok = 1'b0;
    test_reset();
    test_ram_basic();
    test_regs();
    test_timer();
    test_switch();
    test_back_to_back();
    test_random();
    test_reset_write();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
